// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 2-flop input sync, mid-bit sampling, glitch rejection
// and framing-error reporting. Define UART_RX_PARITY_EN for 8E1 framing (default 8N1).
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Active,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Parity_Err
);

    localparam int unsigned      CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF  = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_CLEANUP,
        S_BREAK_WAIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       r_byte;
    logic [7:0]       w_byte_nxt;
    logic             r_dv;
    logic             w_dv_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic             r_par;
    logic             w_par_nxt;
    logic             r_perr;
    logic             w_perr_nxt;
`endif

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= i_RX_Serial;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_byte  <= '0;
            r_dv    <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par   <= 1'b0;
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_byte  <= w_byte_nxt;
            r_dv    <= w_dv_nxt;
            r_ferr  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par   <= w_par_nxt;
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_byte_nxt  = r_byte;
        w_dv_nxt    = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_idx_nxt = '0;
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = r_rx_s;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_par_nxt   = r_rx_s;
                    w_state_nxt = S_STOP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt = '0;
                    // A low stop bit outranks any parity result.
                    if (!r_rx_s) begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK_WAIT;
                    end else begin
                        w_state_nxt = S_CLEANUP;
`ifdef UART_RX_PARITY_EN
                        if (r_par != ^r_shift) begin
                            w_perr_nxt = 1'b1;
                        end else begin
                            w_dv_nxt   = 1'b1;
                            w_byte_nxt = r_shift;
                        end
`else
                        w_dv_nxt   = 1'b1;
                        w_byte_nxt = r_shift;
`endif
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CLEANUP: begin
                w_state_nxt = S_IDLE;
            end
            S_BREAK_WAIT: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_RX_DV        = r_dv;
    assign o_RX_Byte      = r_byte;
    assign o_RX_Frame_Err = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign o_RX_Parity_Err = r_perr;
    assign o_RX_Active     = (r_state == S_START) || (r_state == S_DATA) ||
                             (r_state == S_PARITY) || (r_state == S_STOP);
`else
    assign o_RX_Parity_Err = 1'b0;
    assign o_RX_Active     = (r_state == S_START) || (r_state == S_DATA) ||
                             (r_state == S_STOP);
`endif

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial-to-parallel UART receiver; the downstream counterpart of the UART transmitter.
- Consumes the 8N1 serial line that UART_TX drives on o_TX_Serial (directly in loopback, or from the external pin in the chip).
- Recovers each byte by mid-bit sampling and presents it with a one-cycle valid strobe.
- Flags framing errors and rejects start-bit glitches.

Parameters:
- CLKS_PER_BIT, 217, clocks per serial bit (25 MHz / 115200 baud); legal range 4..65535; must match the UART_TX setting.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_RX_Serial  input  1  asynchronous serial line; idle high.
- o_RX_DV  output  1  one-cycle strobe; o_RX_Byte holds a new good byte.
- o_RX_Byte  output  8  last correctly received byte, LSB first on the wire.
- o_RX_Active  output  1  high while a frame is being received.
- o_RX_Frame_Err  output  1  one-cycle strobe; stop bit sampled low.
- o_RX_Parity_Err  output  1  one-cycle strobe; parity mismatch (see Optional Feature).

Behaviour:
- Reset: async assert on i_Rst_n low.
  - All state clears; FSM goes to IDLE and counters to 0.
  - Both synchroniser flops reset to 1.
  - o_RX_DV, o_RX_Active, o_RX_Frame_Err and o_RX_Parity_Err reset to 0; o_RX_Byte resets to 8'h00.
- Reset mid-frame: the partial byte is discarded; no strobe fires; reception resumes at the next falling edge after release.
- Input sync: 2-flop synchroniser on i_RX_Serial; all decisions use the synchronised bit (rx_s).
- Bit counter: $clog2(CLKS_PER_BIT) bits wide; bit index is 3 bits.
- FSM states:
  - IDLE: o_RX_Active=0; when rx_s==0, go to START with count=0.
  - START: count to HALF=(CLKS_PER_BIT-1)/2 (108 by default).
    - At HALF with rx_s==0: go to DATA, count=0, index=0.
    - At HALF with rx_s==1: glitch; return to IDLE with no strobe.
  - DATA: on count==CLKS_PER_BIT-1, sample rx_s into shift[index]; count=0.
    - index 7 goes to PARITY if the feature is enabled, else to STOP.
  - PARITY (feature only): wait one bit period, sample, then go to STOP.
  - STOP: on count==CLKS_PER_BIT-1, sample rx_s.
    - Sample 1 and no parity error: load o_RX_Byte, pulse o_RX_DV, go to CLEANUP.
    - Sample 1 with parity error: pulse o_RX_Parity_Err, o_RX_Byte unchanged, go to CLEANUP.
    - Sample 0: pulse o_RX_Frame_Err, o_RX_Byte unchanged, go to BREAK_WAIT.
  - CLEANUP: one cycle, then IDLE.
  - BREAK_WAIT: hold until rx_s==1, then IDLE. A break or stuck-low line never retriggers.
- o_RX_Active is 1 in START, DATA, PARITY and STOP; 0 elsewhere.
- Strobes are exactly one cycle. DV and Frame_Err are mutually exclusive; so are DV and Parity_Err.
- Latency, default parameter: o_RX_DV rises 2064 ±3 clocks after the input start-bit falling edge (2 sync + 109 half-bit + 8×217 data + 217 stop).
- Back-to-back frames: a start bit immediately following the stop bit is accepted. CLEANUP ends well before the next start edge reaches HALF.
- No backpressure: the consumer must take o_RX_Byte on o_RX_DV. The byte holds until the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: the frame is 8E1, with an even-parity bit after bit 7 and PARITY state compiled in.
  - Mismatch suppresses DV and pulses o_RX_Parity_Err at the stop-bit sample.
  - A stop error takes precedence: only Frame_Err pulses.
- Undefined: the frame is 8N1; the PARITY state is absent; o_RX_Parity_Err is tied 0.

Test Plan:
- Loopback with UART_TX (CLKS_PER_BIT=217, 40 ns clock), TX sends 8'hAA -> exactly one o_RX_DV, o_RX_Byte==8'hAA, o_RX_Active high for ~9.5 bit periods.
- Back-to-back TX bytes 8'h00, 8'hFF, 8'h3F with no idle gap -> three DV strobes with those values in order; no error strobes.
- Line driven low for 50 clocks then high -> no strobe; o_RX_Active returns to 0 by clock 112; a following valid 8'h55 frame is received correctly.
- Frame 8'hC3 with stop bit forced 0 and the line held low for 3 bit periods -> one o_RX_Frame_Err pulse, no DV, o_RX_Byte keeps its prior value, FSM stays in BREAK_WAIT until the line goes high; no spurious frame follows.
- Reset asserted at data bit 4 of 8'hAA, then released -> no strobe; o_RX_Byte==8'h00; the next frame 8'h5A is received correctly.
- With UART_RX_PARITY_EN: frame 8'h07 with parity bit 1 -> DV and byte 8'h07. Same frame with parity bit 0 -> one o_RX_Parity_Err pulse, no DV.
